// File: rtl/audio_adc_receiver.sv
// audio_adc_receiver: WM8731 I2S ADC capture into a stereo-frame FIFO on Clk.
module audio_adc_receiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            ENABLE,
    input  logic                            AUD_BCLK,
    input  logic                            AUD_ADCLRCK,
    input  logic                            AUD_ADCDAT,
    output logic [2*SAMPLE_BITS-1:0]        ADC_DATA,
    output logic                            ADC_VALID,
    input  logic                            ADC_READY,
    output logic                            ADC_OVERFLOW,
    input  logic                            CLR_OVF,
    output logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

    state_t                   state, next;
    logic [1:0]               bclk_sync, lrck_sync, dat_sync;
    logic                     bclk_prev, lrck_prev;
    logic                     bclk_rise, lr_edge, lr_fall, lr_rise;
    logic [SAMPLE_BITS-1:0]   sh, chan_val, left_reg;
    logic [CW-1:0]            bit_cnt;
    logic                     push, latch_left, pop, full, wr, ovf_set;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LW-1:0]            level;
    logic [2*SAMPLE_BITS-1:0] mem [FIFO_DEPTH];

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lr_edge   = bclk_rise && (lrck_sync[1] != lrck_prev);
    assign lr_fall   = lr_edge && !lrck_sync[1];
    assign lr_rise   = lr_edge && lrck_sync[1];
    // Short channels come out left-justified with zero LSBs
    assign chan_val  = sh << (CW'(SAMPLE_BITS) - bit_cnt);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], AUD_BCLK};
            lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[0], AUD_ADCDAT};
            bclk_prev <= bclk_sync[1];
            if (bclk_rise)
                lrck_prev <= lrck_sync[1];
        end
    end

    // The LRCK-transition rise is the I2S delay slot; later slots past SAMPLE_BITS are dropped
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (bclk_rise) begin
            if (lr_edge) begin
                sh      <= '0;
                bit_cnt <= '0;
            end else if (bit_cnt < CW'(SAMPLE_BITS)) begin
                sh      <= {sh[SAMPLE_BITS-2:0], dat_sync[1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            left_reg <= '0;
        end else begin
            state <= next;
            if (latch_left)
                left_reg <= chan_val;
        end
    end

    always_comb begin
        next       = state;
        push       = 1'b0;
        latch_left = 1'b0;
        if (!ENABLE)
            next = IDLE;
        else begin
            case (state)
                IDLE:  next = ALIGN;
                ALIGN: next = lr_fall ? LEFT : ALIGN;
                LEFT: begin
                    latch_left = lr_rise;
                    next       = lr_rise ? RIGHT : LEFT;
                end
                RIGHT: begin
                    push = lr_fall;
                    next = lr_fall ? LEFT : RIGHT;
                end
                default: next = IDLE;
            endcase
        end
    end

    assign pop     = ADC_VALID && ADC_READY;
    assign full    = level == LW'(FIFO_DEPTH);
    assign wr      = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            ADC_OVERFLOW <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(wr) - LW'(pop);
            if (ovf_set)
                ADC_OVERFLOW <= 1'b1;
            else if (CLR_OVF)
                ADC_OVERFLOW <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr)
            mem[wr_ptr] <= {left_reg, chan_val};
    end

    assign ADC_VALID  = level != '0;
    assign ADC_DATA   = ADC_VALID ? mem[rd_ptr] : '0;
    assign FIFO_LEVEL = level;
endmodule

// File: tb/tb_audio_adc_receiver.sv
// tb_audio_adc_receiver: directed I2S frames against hand-computed FIFO contents.
module tb_audio_adc_receiver;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ENABLE = 1'b0;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_ADCLRCK = 1'b0;
    logic        AUD_ADCDAT = 1'b0;
    logic [31:0] ADC_DATA;
    logic        ADC_VALID;
    logic        ADC_READY = 1'b0;
    logic        ADC_OVERFLOW;
    logic        CLR_OVF = 1'b0;
    logic [2:0]  FIFO_LEVEL;
    int          n_checks = 0;
    int          n_fail = 0;

    audio_adc_receiver dut (
        .Clk(Clk), .Reset(Reset), .ENABLE(ENABLE),
        .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
        .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID), .ADC_READY(ADC_READY),
        .ADC_OVERFLOW(ADC_OVERFLOW), .CLR_OVF(CLR_OVF), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One BCLK period (8 Clk); LRCK/DAT change while BCLK is low
    task automatic send_bit(input logic lr, input logic d);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        #40;
        AUD_BCLK = 1'b1;
        #40;
    endtask

    task automatic send_chan(input logic lr, input logic [31:0] v, input int n);
        send_bit(lr, 1'b0);
        for (int i = n - 1; i >= 0; i--)
            send_bit(lr, v[i]);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_chan(1'b0, {16'h0, l}, 16);
        send_chan(1'b1, {16'h0, r}, 16);
    endtask

    task automatic start_seg();
        ENABLE = 1'b0;
        #20;
        ENABLE = 1'b1;
        #20;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, ADC_VALID, 1);
        check({tag, "_data"}, ADC_DATA, exp);
        ADC_READY = 1'b1;
        #10;
        ADC_READY = 1'b0;
    endtask

    initial begin
        #20;
        check("rst_valid", ADC_VALID, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_data", ADC_DATA, 0);
        check("rst_ovf", ADC_OVERFLOW, 0);
        Reset = 1'b1;
        #20;

        start_seg();
        send_frame(16'hA5C3, 16'h3C5A);
        send_bit(1'b0, 1'b0);
        #20;
        check("basic_level", FIFO_LEVEL, 1);
        pop_check("basic", 32'hA5C33C5A);
        check("basic_level0", FIFO_LEVEL, 0);
        check("basic_valid0", ADC_VALID, 0);

        ENABLE = 1'b0;
        #20;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        ENABLE = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        send_frame(16'h1111, 16'h2222);
        send_bit(1'b0, 1'b0);
        #20;
        check("midr_level", FIFO_LEVEL, 1);
        pop_check("midr", 32'h11112222);

        start_seg();
        for (int k = 1; k <= 5; k++)
            send_frame(16'(k), 16'(16'h8000 + k));
        send_bit(1'b0, 1'b0);
        #20;
        check("ovf_level", FIFO_LEVEL, 4);
        check("ovf_flag", ADC_OVERFLOW, 1);
        for (int k = 1; k <= 4; k++)
            pop_check("ovf_pop", {16'(k), 16'(16'h8000 + k)});
        check("ovf_level0", FIFO_LEVEL, 0);
        check("ovf_sticky", ADC_OVERFLOW, 1);
        CLR_OVF = 1'b1;
        #10;
        CLR_OVF = 1'b0;
        check("ovf_clr", ADC_OVERFLOW, 0);

        start_seg();
        for (int k = 10; k <= 14; k++)
            send_frame(16'(k), 16'(16'h4000 + k));
        #20;
        check("fullpp_pre_level", FIFO_LEVEL, 4);
        check("fullpp_pre_head", ADC_DATA, {16'd10, 16'h400A});
        fork
            send_bit(1'b0, 1'b0);
            begin
                #60;
                ADC_READY = 1'b1;
                #10;
                ADC_READY = 1'b0;
            end
        join
        #20;
        check("fullpp_level", FIFO_LEVEL, 4);
        check("fullpp_ovf", ADC_OVERFLOW, 0);
        for (int k = 11; k <= 14; k++)
            pop_check("fullpp_pop", {16'(k), 16'(16'h4000 + k)});

        start_seg();
        send_chan(1'b0, 32'h5555, 16);
        send_chan(1'b1, 32'hFFF, 12);
        send_chan(1'b0, 32'h12345, 20);
        send_chan(1'b1, 32'h00FF, 16);
        send_bit(1'b0, 1'b0);
        #20;
        check("just_level", FIFO_LEVEL, 2);
        pop_check("just_short", 32'h5555FFF0);
        pop_check("just_long", 32'h123400FF);

        start_seg();
        send_frame(16'hAAAA, 16'hBBBB);
        send_frame(16'hCCCC, 16'hDDDD);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        check("rstmid_pre_level", FIFO_LEVEL, 2);
        Reset = 1'b0;
        #1;
        check("rstmid_level", FIFO_LEVEL, 0);
        check("rstmid_valid", ADC_VALID, 0);
        check("rstmid_data", ADC_DATA, 0);
        check("rstmid_ovf", ADC_OVERFLOW, 0);
        #19;
        Reset = 1'b1;
        #20;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(16'h1357, 16'h2468);
        send_frame(16'h9ABC, 16'hDEF0);
        send_bit(1'b0, 1'b0);
        #20;
        check("rstmid_new_level", FIFO_LEVEL, 2);
        pop_check("rstmid_new0", 32'h13572468);
        pop_check("rstmid_new1", 32'h9ABCDEF0);
        check("rstmid_empty", FIFO_LEVEL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/audio_adc_receiver.md
AUDIO_ADC_RECEIVER -- requirements
Module: audio_adc_receiver

Interface
REQ-001 Parameter SAMPLE_BITS, default 16, bits captured per channel.
REQ-002 Parameter FIFO_DEPTH, default 4, number of stereo frames buffered (power of two).
REQ-003 Port Clk  input  1  system clock, all state on rising edge.
REQ-004 Port Reset  input  1  reset, asynchronous, active-low.
REQ-005 Port ENABLE  input  1  capture enable (Clk domain).
REQ-006 Port AUD_BCLK  input  1  WM8731 bit clock, asynchronous to Clk.
REQ-007 Port AUD_ADCLRCK  input  1  WM8731 ADC LR clock: low = left, high = right.
REQ-008 Port AUD_ADCDAT  input  1  WM8731 ADC serial data, MSB first, I2S format.
REQ-009 Port ADC_DATA  output  2*SAMPLE_BITS  FIFO head frame {left, right}.
REQ-010 Port ADC_VALID  output  1  FIFO non-empty; ADC_DATA is valid.
REQ-011 Port ADC_READY  input  1  consumer accepts head frame when ADC_VALID && ADC_READY.
REQ-012 Port ADC_OVERFLOW  output  1  sticky: frame dropped because FIFO was full.
REQ-013 Port CLR_OVF  input  1  one-cycle pulse clearing ADC_OVERFLOW.
REQ-014 Port FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  frames currently stored.

Function
REQ-015 AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT each pass a 2-flop synchronizer to Clk; BCLK rising edge detected from synchronized samples (one-cycle strobe).
REQ-016 All serial sampling occurs only on the BCLK-rise strobe; LRCK and DAT used are the synchronized values in that cycle.
REQ-017 LRCK transition = sampled LRCK differs from value at previous BCLK rise; that BCLK rise is slot 0 (I2S delay bit, data ignored).
REQ-018 Slots 1..SAMPLE_BITS shift DAT into the current channel register MSB first; slots beyond SAMPLE_BITS ignored.
REQ-019 Channel ending with fewer than SAMPLE_BITS bits: received bits left-justified, missing LSBs = 0.
REQ-020 State machine IDLE, ALIGN, LEFT, RIGHT; reset state IDLE.
REQ-021 IDLE: ENABLE=1 -> ALIGN; no capture.
REQ-022 ALIGN: LRCK 1->0 transition -> LEFT (that rise is slot 0); all other rises ignored.
REQ-023 LEFT: LRCK 0->1 transition -> RIGHT, left register latched.
REQ-024 RIGHT: LRCK 1->0 transition -> push {left,right} to FIFO, -> LEFT (same rise is slot 0 of new left).
REQ-025 ENABLE=0 in any state -> IDLE next cycle; partial frame discarded; FIFO contents and ADC_OVERFLOW retained.
REQ-026 Push is a one-Clk event; ADC_VALID and FIFO_LEVEL reflect it on the next Clk edge.
REQ-027 Pop occurs on Clk edge with ADC_VALID && ADC_READY; ADC_DATA shows next entry next cycle; ADC_DATA is don't-care when ADC_VALID=0.
REQ-028 Push with FIFO full and no pop in same cycle: frame dropped, contents unchanged, ADC_OVERFLOW set.
REQ-029 Push and pop in same cycle when full: both performed, no overflow, level unchanged.
REQ-030 Push and pop in same cycle when 1 < level < full: level unchanged, order preserved.
REQ-031 CLR_OVF clears ADC_OVERFLOW; overflow event in same cycle as CLR_OVF leaves ADC_OVERFLOW=1.
REQ-032 Read/write pointers wrap modulo FIFO_DEPTH; FIFO_LEVEL range 0..FIFO_DEPTH.

Reset
REQ-033 Reset low asynchronously forces: state IDLE, FIFO empty, FIFO_LEVEL=0, ADC_VALID=0, ADC_OVERFLOW=0, ADC_DATA=0, synchronizers and shift registers 0.
REQ-034 Reset mid-frame discards partial frame and FIFO; after release capture restarts via ALIGN (IDLE if ENABLE=0).
REQ-035 Reset release synchronous to Clk; no push within the first 2 Clk cycles after release.

Verification
REQ-036 ENABLE=1, BCLK=Clk/8, I2S frames left=16'hA5C3 right=16'h3C5A -> ADC_VALID after first complete frame, ADC_DATA=32'hA5C33C5A; ADC_READY=1 pops, FIFO_LEVEL returns 0.
REQ-037 Enable while LRCK high mid right channel -> that partial frame not pushed; first pushed frame is first full L/R pair.
REQ-038 ADC_READY=0, send 5 frames (1..5) with FIFO_DEPTH=4 -> FIFO_LEVEL=4, ADC_OVERFLOW=1, pops return frames 1,2,3,4; CLR_OVF pulse -> ADC_OVERFLOW=0.
REQ-039 FIFO full, ADC_READY held 1 over push cycle -> no overflow, FIFO_LEVEL stays 4, frame order intact.
REQ-040 Right channel of 12 bits 12'hFFF -> right=16'hFFF0; 20-bit channel 20'h12345 -> value 16'h1234.
REQ-041 Reset low mid left channel with 2 frames buffered -> all outputs 0 immediately; after release and 2 new frames, ADC_DATA equals first new frame.
